// File: rtl/tcm_port_arbiter_pkg.sv
// Shared widths, owner codes and FSM state type for the TCM port arbiter.
package tcm_port_arbiter_pkg;

    localparam int XLEN        = 32;
    localparam int BUS_WIDTH   = 32;
    localparam int BUS_ACC_CNT = 3;
    localparam int ACC_W       = $clog2(BUS_ACC_CNT);

    typedef enum logic [1:0] {
        ARB_OWN_D = 2'd0,
        ARB_OWN_I = 2'd1,
        ARB_OWN_X = 2'd2
    } arb_own_e;

    typedef enum logic {
        ARB_ST_IDLE = 1'b0,
        ARB_ST_BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/tcm_port_arbiter_age_picker.sv
// Combinational winner selection: starved requesters first, then D > I > X.
// Bit 0 = D, bit 1 = I, bit 2 = X.
module arb_age_picker
    import tcm_port_arbiter_pkg::*;
(
    input  logic [2:0] req_i,
    input  logic [2:0] starved_i,
    output logic [2:0] gnt_o,
    output logic [1:0] owner_o
);

    logic [2:0] hi_pool;
    logic [2:0] pool;

    // Restrict the candidate set to starved requesters when any exist, then apply fixed priority.
    always_comb begin
        hi_pool = req_i & starved_i;
        pool    = (|hi_pool) ? hi_pool : req_i;
        gnt_o   = '0;
        owner_o = ARB_OWN_D;
        if (pool[0]) begin
            gnt_o   = 3'b001;
            owner_o = ARB_OWN_D;
        end else if (pool[1]) begin
            gnt_o   = 3'b010;
            owner_o = ARB_OWN_I;
        end else if (pool[2]) begin
            gnt_o   = 3'b100;
            owner_o = ARB_OWN_X;
        end
    end

endmodule

// File: rtl/tcm_port_arbiter.sv
// Shares the single TCM port between data, instruction and external masters.
// One transaction at a time; aging prevents starvation, watchdog faults hung accesses.
module tcm_port_arbiter
    import tcm_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic                 clk,
    input  logic                 rstn,

    input  logic [XLEN-1:0]      d_addr,
    input  logic                 d_w_rb,
    input  logic [ACC_W-1:0]     d_acc,
    input  logic [BUS_WIDTH-1:0] d_wdata,
    input  logic                 d_req,
    output logic [BUS_WIDTH-1:0] d_rdata,
    output logic                 d_resp,
    output logic                 d_fault,

    input  logic [XLEN-1:0]      i_addr,
    input  logic                 i_w_rb,
    input  logic [ACC_W-1:0]     i_acc,
    input  logic [BUS_WIDTH-1:0] i_wdata,
    input  logic                 i_req,
    output logic [BUS_WIDTH-1:0] i_rdata,
    output logic                 i_resp,
    output logic                 i_fault,

    input  logic [XLEN-1:0]      x_addr,
    input  logic                 x_w_rb,
    input  logic [ACC_W-1:0]     x_acc,
    input  logic [BUS_WIDTH-1:0] x_wdata,
    input  logic                 x_req,
    output logic [BUS_WIDTH-1:0] x_rdata,
    output logic                 x_resp,
    output logic                 x_fault,

    output logic [XLEN-1:0]      addr,
    output logic                 w_rb,
    output logic [ACC_W-1:0]     acc,
    output logic [BUS_WIDTH-1:0] wdata,
    output logic                 req,
    input  logic [BUS_WIDTH-1:0] rdata,
    input  logic                 resp,
    input  logic                 fault
);

    localparam logic [3:0] AGE_LIM  = 4'(STARVE_LIMIT);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    arb_state_e           state_q;
    logic [1:0]           owner_q;
    logic [XLEN-1:0]      addr_q;
    logic                 w_rb_q;
    logic [ACC_W-1:0]     acc_q;
    logic [BUS_WIDTH-1:0] wdata_q;
    logic                 req_q;
    logic [7:0]           tmo_q;
    logic [3:0]           age_q [3];
    logic [3:0]           age_d [3];

    logic [2:0]           mreq;
    logic [2:0]           starved;
    logic [2:0]           gnt;
    logic [1:0]           win_owner;
    logic                 grant_now;
    logic                 busy;
    logic                 tmo_hit;
    logic                 done;
    logic                 done_fault;

    logic [XLEN-1:0]      sel_addr;
    logic                 sel_w_rb;
    logic [ACC_W-1:0]     sel_acc;
    logic [BUS_WIDTH-1:0] sel_wdata;

    assign mreq = {x_req, i_req, d_req};

    // A requester is starved once its age counter has saturated at the limit.
    always_comb begin
        for (int unsigned k = 0; k < 3; k++) begin
            starved[k] = (age_q[k] == AGE_LIM);
        end
    end

    arb_age_picker u_picker (
        .req_i     (mreq),
        .starved_i (starved),
        .gnt_o     (gnt),
        .owner_o   (win_owner)
    );

    assign grant_now  = (state_q == ARB_ST_IDLE) && (|mreq);
    assign busy       = (state_q == ARB_ST_BUSY);
    assign tmo_hit    = (TIMEOUT != 0) && (tmo_q == TMO_LAST);
    assign done       = busy && (resp || tmo_hit);
    // A real response takes precedence over a coincident watchdog expiry.
    assign done_fault = resp ? fault : 1'b1;

    assign d_resp  = done && (owner_q == ARB_OWN_D);
    assign i_resp  = done && (owner_q == ARB_OWN_I);
    assign x_resp  = done && (owner_q == ARB_OWN_X);
    assign d_fault = d_resp && done_fault;
    assign i_fault = i_resp && done_fault;
    assign x_fault = x_resp && done_fault;
    assign d_rdata = rdata;
    assign i_rdata = rdata;
    assign x_rdata = rdata;

    assign addr  = addr_q;
    assign w_rb  = w_rb_q;
    assign acc   = acc_q;
    assign wdata = wdata_q;
    assign req   = req_q;

    // Route the winning master's transaction fields toward the downstream registers.
    always_comb begin
        sel_addr  = d_addr;
        sel_w_rb  = d_w_rb;
        sel_acc   = d_acc;
        sel_wdata = d_wdata;
        if (win_owner == ARB_OWN_I) begin
            sel_addr  = i_addr;
            sel_w_rb  = i_w_rb;
            sel_acc   = i_acc;
            sel_wdata = i_wdata;
        end else if (win_owner == ARB_OWN_X) begin
            sel_addr  = x_addr;
            sel_w_rb  = x_w_rb;
            sel_acc   = x_acc;
            sel_wdata = x_wdata;
        end
    end

    // Age update: idle requesters clear, losers of a grant age (saturating), the winner clears.
    always_comb begin
        for (int unsigned k = 0; k < 3; k++) begin
            age_d[k] = age_q[k];
            if (!mreq[k]) begin
                age_d[k] = '0;
            end else if (grant_now) begin
                if (gnt[k]) begin
                    age_d[k] = '0;
                end else if (age_q[k] != AGE_LIM) begin
                    age_d[k] = age_q[k] + 4'd1;
                end
            end
        end
    end

    // Arbitration FSM with registered downstream request, owner, ages and watchdog.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ARB_ST_IDLE;
            owner_q <= ARB_OWN_D;
            addr_q  <= '0;
            w_rb_q  <= 1'b0;
            acc_q   <= '0;
            wdata_q <= '0;
            req_q   <= 1'b0;
            tmo_q   <= '0;
            for (int unsigned k = 0; k < 3; k++) begin
                age_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < 3; k++) begin
                age_q[k] <= age_d[k];
            end
            if (state_q == ARB_ST_IDLE) begin
                if (grant_now) begin
                    addr_q  <= sel_addr;
                    w_rb_q  <= sel_w_rb;
                    acc_q   <= sel_acc;
                    wdata_q <= sel_wdata;
                    req_q   <= 1'b1;
                    owner_q <= win_owner;
                    tmo_q   <= '0;
                    state_q <= ARB_ST_BUSY;
                end
            end else begin
                if (done) begin
                    req_q   <= 1'b0;
                    tmo_q   <= '0;
                    state_q <= ARB_ST_IDLE;
                end else begin
                    tmo_q <= tmo_q + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tcm_port_arbiter.sv
// Scoreboard bench for tcm_port_arbiter: directed stimulus pushes expected
// completions, a negedge monitor pops and compares on every master response.
module tb_tcm_port_arbiter;
    import tcm_port_arbiter_pkg::*;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic [XLEN-1:0]      d_addr, i_addr, x_addr;
    logic                 d_w_rb, i_w_rb, x_w_rb;
    logic [ACC_W-1:0]     d_acc, i_acc, x_acc;
    logic [BUS_WIDTH-1:0] d_wdata, i_wdata, x_wdata;
    logic                 d_req, i_req, x_req;
    logic [BUS_WIDTH-1:0] d_rdata, i_rdata, x_rdata;
    logic                 d_resp, i_resp, x_resp;
    logic                 d_fault, i_fault, x_fault;
    logic [XLEN-1:0]      addr;
    logic                 w_rb;
    logic [ACC_W-1:0]     acc;
    logic [BUS_WIDTH-1:0] wdata;
    logic                 req;
    logic [BUS_WIDTH-1:0] rdata;
    logic                 resp;
    logic                 fault;

    typedef struct {
        logic [1:0]  owner;
        logic [31:0] addr;
        logic        w_rb;
        logic [1:0]  acc;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        fault;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    tcm_port_arbiter #(.STARVE_LIMIT(2), .TIMEOUT(8)) dut (
        .clk(clk), .rstn(rstn),
        .d_addr(d_addr), .d_w_rb(d_w_rb), .d_acc(d_acc), .d_wdata(d_wdata), .d_req(d_req),
        .d_rdata(d_rdata), .d_resp(d_resp), .d_fault(d_fault),
        .i_addr(i_addr), .i_w_rb(i_w_rb), .i_acc(i_acc), .i_wdata(i_wdata), .i_req(i_req),
        .i_rdata(i_rdata), .i_resp(i_resp), .i_fault(i_fault),
        .x_addr(x_addr), .x_w_rb(x_w_rb), .x_acc(x_acc), .x_wdata(x_wdata), .x_req(x_req),
        .x_rdata(x_rdata), .x_resp(x_resp), .x_fault(x_fault),
        .addr(addr), .w_rb(w_rb), .acc(acc), .wdata(wdata), .req(req),
        .rdata(rdata), .resp(resp), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int m, input logic r, input logic [31:0] a, input logic w,
                         input logic [1:0] ac, input logic [31:0] wd);
        case (m)
            0: begin d_req = r; d_addr = a; d_w_rb = w; d_acc = ac; d_wdata = wd; end
            1: begin i_req = r; i_addr = a; i_w_rb = w; i_acc = ac; i_wdata = wd; end
            default: begin x_req = r; x_addr = a; x_w_rb = w; x_acc = ac; x_wdata = wd; end
        endcase
    endtask

    task automatic push(input logic [1:0] own, input logic [31:0] a, input logic w,
                        input logic [1:0] ac, input logic [31:0] wd, input logic [31:0] rd,
                        input logic f);
        exp_t e;
        e.owner = own; e.addr = a; e.w_rb = w; e.acc = ac;
        e.wdata = wd; e.rdata = rd; e.fault = f;
        sb.push_back(e);
    endtask

    // Wait (bounded) for the downstream request, answer it k cycles later, return in the following IDLE cycle.
    task automatic serve(input int k, input logic [31:0] rd, input logic f);
        int n = 0;
        while (req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("req_seen", req, 1);
        repeat (k) tick();
        rdata = rd;
        fault = f;
        resp  = 1'b1;
        tick();
        resp  = 1'b0;
        fault = 1'b0;
        chk("req_drop", req, 0);
    endtask

    // Monitor: every master response must match the oldest expected completion.
    always @(negedge clk) begin
        if ({x_resp, i_resp, d_resp} != 3'b000) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", {x_resp, i_resp, d_resp}, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("resp_owner", {x_resp, i_resp, d_resp}, 64'(3'b001 << mon_e.owner));
                chk("fault_vec", {x_fault, i_fault, d_fault},
                    mon_e.fault ? 64'(3'b001 << mon_e.owner) : 64'd0);
                chk("d_rdata", d_rdata, mon_e.rdata);
                chk("i_rdata", i_rdata, mon_e.rdata);
                chk("x_rdata", x_rdata, mon_e.rdata);
                chk("ds_addr", addr, mon_e.addr);
                chk("ds_w_rb", w_rb, mon_e.w_rb);
                chk("ds_acc", acc, mon_e.acc);
                chk("ds_wdata", wdata, mon_e.wdata);
                chk("ds_req", req, 1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: got 0x0 expected 0x1");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rstn = 1'b0; resp = 1'b0; fault = 1'b0; rdata = '0;
        set_m(0, 0, 0, 0, 0, 0);
        set_m(1, 0, 0, 0, 0, 0);
        set_m(2, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk("rst_req", req, 0);
        chk("rst_addr", addr, 0);
        chk("rst_w_rb", w_rb, 0);
        chk("rst_acc", acc, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_resp", {x_resp, i_resp, d_resp}, 0);
        rstn = 1'b1;
        tick();

        // Single read from I: downstream req one cycle later, i_resp two cycles after i_req.
        set_m(1, 1, 32'h100, 0, 2, 0);
        push(ARB_OWN_I, 32'h100, 0, 2, 0, 32'hDEADBEEF, 0);
        tick();
        chk("single_req", req, 1);
        chk("single_addr", addr, 32'h100);
        tick();
        rdata = 32'hDEADBEEF;
        resp  = 1'b1;
        #1;
        chk("single_i_resp", i_resp, 1);
        chk("single_i_rdata", i_rdata, 32'hDEADBEEF);
        chk("single_dx_resp", {x_resp, d_resp}, 0);
        tick();
        resp = 1'b0;
        set_m(1, 0, 32'h100, 0, 2, 0);
        chk("single_req_drop", req, 0);
        tick();

        // Simultaneous D, I, X: D first, then I (X age 1 < 2), then X.
        set_m(0, 1, 32'h10, 1, 0, 32'hAAAA0001);
        set_m(1, 1, 32'h20, 0, 1, 32'hBBBB0002);
        set_m(2, 1, 32'h30, 1, 2, 32'hCCCC0003);
        push(ARB_OWN_D, 32'h10, 1, 0, 32'hAAAA0001, 32'h11111111, 0);
        serve(1, 32'h11111111, 0);
        d_req = 1'b0;
        push(ARB_OWN_I, 32'h20, 0, 1, 32'hBBBB0002, 32'h22222222, 0);
        serve(2, 32'h22222222, 0);
        i_req = 1'b0;
        push(ARB_OWN_X, 32'h30, 1, 2, 32'hCCCC0003, 32'h33333333, 0);
        serve(1, 32'h33333333, 0);
        x_req = 1'b0;
        tick();

        // Starvation with limit 2: D,I continuous, X joins at arb 2.
        // Ages after arb1 D:{I1}; arb2 D:{I2,X1}; arb3 I (starved):{D1,X2}; arb4 X (starved).
        set_m(0, 1, 32'h400, 0, 2, 0);
        set_m(1, 1, 32'h500, 0, 2, 0);
        push(ARB_OWN_D, 32'h400, 0, 2, 0, 32'h44440001, 0);
        serve(1, 32'h44440001, 0);
        set_m(0, 1, 32'h404, 0, 2, 0);
        set_m(2, 1, 32'h600, 1, 0, 32'h000000EE);
        push(ARB_OWN_D, 32'h404, 0, 2, 0, 32'h44440002, 0);
        serve(2, 32'h44440002, 0);
        push(ARB_OWN_I, 32'h500, 0, 2, 0, 32'h55550001, 0);
        serve(1, 32'h55550001, 0);
        push(ARB_OWN_X, 32'h600, 1, 0, 32'h000000EE, 32'h66660001, 0);
        serve(3, 32'h66660001, 0);
        d_req = 1'b0; i_req = 1'b0; x_req = 1'b0;
        tick();

        // Watchdog: no TCM response, fault pulse in the 8th BUSY cycle, then req drops.
        rdata = 32'h0BADF00D;
        set_m(0, 1, 32'h700, 0, 1, 0);
        push(ARB_OWN_D, 32'h700, 0, 1, 0, 32'h0BADF00D, 1);
        tick();
        for (int c = 1; c <= 8; c++) begin
            chk("tmo_d_resp", d_resp, (c == 8) ? 1 : 0);
            chk("tmo_d_fault", d_fault, (c == 8) ? 1 : 0);
            if (c < 8) tick();
        end
        tick();
        chk("tmo_req_drop", req, 0);
        d_req = 1'b0;
        resp  = 1'b1;
        #1;
        chk("late_resp_drop", {x_resp, i_resp, d_resp}, 0);
        tick();
        resp = 1'b0;
        chk("late_resp_idle", req, 0);
        tick();

        // resp coinciding with the watchdog expiry: resp wins, fault follows downstream (0).
        set_m(1, 1, 32'h800, 0, 2, 0);
        push(ARB_OWN_I, 32'h800, 0, 2, 0, 32'h88880001, 0);
        serve(7, 32'h88880001, 0);
        i_req = 1'b0;
        tick();

        // Fault pass-through on an X write.
        set_m(2, 1, 32'h204, 1, 2, 32'hCAFEF00D);
        push(ARB_OWN_X, 32'h204, 1, 2, 32'hCAFEF00D, 32'h99990001, 1);
        serve(2, 32'h99990001, 1);
        x_req = 1'b0;
        tick();

        // Reset while BUSY: everything clears, no owner resp, later downstream resp dropped.
        set_m(0, 1, 32'h300, 1, 1, 32'h00000055);
        tick();
        chk("rstbusy_req", req, 1);
        tick();
        rstn = 1'b0;
        tick();
        chk("rstbusy_req0", req, 0);
        chk("rstbusy_addr", addr, 0);
        chk("rstbusy_w_rb", w_rb, 0);
        chk("rstbusy_acc", acc, 0);
        chk("rstbusy_wdata", wdata, 0);
        chk("rstbusy_resp", {x_resp, i_resp, d_resp}, 0);
        d_req = 1'b0;
        rstn  = 1'b1;
        tick();
        resp = 1'b1;
        #1;
        chk("rstbusy_late_resp", {x_resp, i_resp, d_resp}, 0);
        tick();
        resp = 1'b0;
        chk("rstbusy_idle", req, 0);

        repeat (3) tick();
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
